vga_timing_gen: RTL

Generates VGA raster timing for the display pipeline: horizontal/vertical pixel counters, active-low sync pulses, and the `bright` visible-area flag. It sits directly upstream of the tile-map bit generator, which consumes `hCount`, `vCount` and `bright` on the same clock. It also feeds `hSync`/`vSync` to the board pins. A pixel-enable divider derives the pixel rate from the system clock. Frame and vertical-blank strobes let game logic update tile memory safely.

---
 rtl/vga_timing_gen.sv | 96 +++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, h/v counters, registered sync/bright/blank/frame strobes.
// Latency: every output is registered from next-state counters, so flags and counts agree each clk.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pixelEn,
    output logic       frameStart,
    output logic       vblank
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);

    // Decode bounds are 11 bits so a sync region ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic [DW-1:0] div_next;
    logic          run;
    logic [9:0]    h_next;
    logic [9:0]    v_next;
    logic          line_end;
    logic          frame_end;

    // The divider holds phase 0 for the first clk out of reset so pixelEn lands at clk CLK_DIV-1.
    always_comb begin
        div_next = div;
        if (run) begin
            div_next = (div == DIV_LAST) ? '0 : div + DW'(1);
        end

        line_end  = pixelEn && (hCount == H_LAST);
        frame_end = line_end && (vCount == V_LAST);

        h_next = hCount;
        v_next = vCount;
        if (pixelEn) begin
            h_next = line_end ? 10'd0 : hCount + 10'd1;
        end
        if (line_end) begin
            v_next = frame_end ? 10'd0 : vCount + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run        <= 1'b0;
            div        <= '0;
            pixelEn    <= 1'b0;
            hCount     <= 10'd0;
            vCount     <= 10'd0;
            hSync      <= 1'b1;
            vSync      <= 1'b1;
            bright     <= 1'b0;
            vblank     <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            run        <= 1'b1;
            div        <= div_next;
            pixelEn    <= (div_next == DIV_LAST);
            hCount     <= h_next;
            vCount     <= v_next;
            hSync      <= !(({1'b0, h_next} >= HS_START) && ({1'b0, h_next} < HS_END));
            vSync      <= !(({1'b0, v_next} >= VS_START) && ({1'b0, v_next} < VS_END));
            bright     <= ({1'b0, h_next} < H_VIS_END) && ({1'b0, v_next} < V_VIS_END);
            vblank     <= ({1'b0, v_next} >= V_VIS_END);
            frameStart <= frame_end;
        end
    end

endmodule
